// File: rtl/clock_div_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : clock_div_pkg
//  Description : Shared types, reset configuration and write-time clamp
//                helpers for the multi-channel clock divider.
//  Revision    : 1.0 - initial release
// ============================================================================
package clock_div_pkg;

    localparam int DIV_W_DEF = 16;

    // Configuration a channel holds after reset
    localparam int DIV_RST   = 2;
    localparam int HIGH_RST  = 1;
    localparam int PHASE_RST = 0;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_STOPPING = 2'd2
    } ch_state_e;

    // The clamp helpers work on 32-bit values so they can serve any field
    // width up to 32; callers cast the result back to their own width.

    // A period shorter than two cycles cannot show both levels.
    function automatic logic [31:0] clamp_div(input logic [31:0] div);
        return (div < 32'd2) ? 32'd2 : div;
    endfunction

    // High time must leave at least one low cycle and one high cycle.
    function automatic logic [31:0] clamp_high(input logic [31:0] high,
                                               input logic [31:0] div_c);
        logic [31:0] h;
        h = (high < 32'd1) ? 32'd1 : high;
        if (h > div_c - 32'd1) begin
            h = div_c - 32'd1;
        end
        return h;
    endfunction

    // An out-of-range phase would never match the wrap point; fall back to 0.
    function automatic logic [31:0] clamp_phase(input logic [31:0] phase,
                                                input logic [31:0] div_c);
        return (phase < div_c) ? phase : 32'd0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/clock_div_channel.sv
`default_nettype none
// ============================================================================
//  Module      : clock_div_channel
//  Description : One divided-clock channel: period counter, active and
//                shadow configuration, start / glitch-free stop / sync FSM.
//  Revision    : 1.0 - initial release
//
//  Ports
//    clk_i      master clock            rst_ni     async active-low reset
//    we_i       config write (this ch)  div_i/high_i/phase_i  clamped config
//    en_i       run request             sync_i     common restart
//    clk_out_o  divided clock (flop)    tick_o     cnt==0 strobe (flop)
//    running_o  channel counting        pending_o  shadow awaiting wrap
// ============================================================================
module clock_div_channel
    import clock_div_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEF
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             we_i,
    input  logic [DIV_W-1:0] div_i,
    input  logic [DIV_W-1:0] high_i,
    input  logic [DIV_W-1:0] phase_i,
    input  logic             en_i,
    input  logic             sync_i,
    output logic             clk_out_o,
    output logic             tick_o,
    output logic             running_o,
    output logic             pending_o
);

    ch_state_e        state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] div_q, div_d, high_q, high_d, phase_q, phase_d;
    logic [DIV_W-1:0] sdiv_q, sdiv_d, shigh_q, shigh_d, sphase_q, sphase_d;
    logic             pend_q, pend_d;
    logic             clk_out_q, clk_out_d, tick_q, tick_d;

    // Configuration selected to be in force after this edge
    logic [DIV_W-1:0] w_sel_div, w_sel_high, w_sel_phase;
    logic [DIV_W-1:0] w_cnt_inc;
    logic             w_wrap;

    assign w_cnt_inc = cnt_q + 1'b1;
    assign w_wrap    = (cnt_q == div_q - 1'b1);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        div_d       = div_q;
        high_d      = high_q;
        phase_d     = phase_q;
        sdiv_d      = sdiv_q;
        shigh_d     = shigh_q;
        sphase_d    = sphase_q;
        pend_d      = pend_q;
        clk_out_d   = clk_out_q;
        tick_d      = tick_q;
        w_sel_div   = div_q;
        w_sel_high  = high_q;
        w_sel_phase = phase_q;

        case (state_q)
            ST_IDLE: begin
                // Idle writes go straight to the active set, so a write in
                // the same cycle as the start is used for that start.
                if (we_i) begin
                    w_sel_div   = div_i;
                    w_sel_high  = high_i;
                    w_sel_phase = phase_i;
                    sdiv_d      = div_i;
                    shigh_d     = high_i;
                    sphase_d    = phase_i;
                end
                div_d   = w_sel_div;
                high_d  = w_sel_high;
                phase_d = w_sel_phase;
                if (en_i) begin
                    state_d   = ST_RUN;
                    cnt_d     = w_sel_phase;
                    clk_out_d = (w_sel_phase < w_sel_high);
                    tick_d    = (w_sel_phase == '0);
                end
            end

            default: begin
                if (en_i && sync_i) begin
                    // A write coinciding with sync beats any older shadow.
                    if (we_i) begin
                        w_sel_div   = div_i;
                        w_sel_high  = high_i;
                        w_sel_phase = phase_i;
                    end else if (pend_q) begin
                        w_sel_div   = sdiv_q;
                        w_sel_high  = shigh_q;
                        w_sel_phase = sphase_q;
                    end
                    div_d     = w_sel_div;
                    high_d    = w_sel_high;
                    phase_d   = w_sel_phase;
                    pend_d    = 1'b0;
                    state_d   = ST_RUN;
                    cnt_d     = w_sel_phase;
                    clk_out_d = (w_sel_phase < w_sel_high);
                    tick_d    = (w_sel_phase == '0);
                end else if (w_wrap) begin
                    if (pend_q) begin
                        w_sel_div   = sdiv_q;
                        w_sel_high  = shigh_q;
                        w_sel_phase = sphase_q;
                    end
                    pend_d = 1'b0;
                    cnt_d  = '0;
                    if (en_i) begin
                        state_d   = ST_RUN;
                        clk_out_d = 1'b1;   // high time is never below 1
                        tick_d    = 1'b1;
                        if (we_i) begin
                            sdiv_d   = div_i;
                            shigh_d  = high_i;
                            sphase_d = phase_i;
                            pend_d   = 1'b1;
                        end
                    end else begin
                        // Period complete with no run request: go idle.
                        // A write landing here is treated as an idle write.
                        state_d   = ST_IDLE;
                        clk_out_d = 1'b0;
                        tick_d    = 1'b0;
                        if (we_i) begin
                            w_sel_div   = div_i;
                            w_sel_high  = high_i;
                            w_sel_phase = phase_i;
                            sdiv_d      = div_i;
                            shigh_d     = high_i;
                            sphase_d    = phase_i;
                        end
                    end
                    div_d   = w_sel_div;
                    high_d  = w_sel_high;
                    phase_d = w_sel_phase;
                end else begin
                    cnt_d     = w_cnt_inc;
                    clk_out_d = (w_cnt_inc < high_q);
                    tick_d    = 1'b0;
                    state_d   = en_i ? ST_RUN : ST_STOPPING;
                    if (we_i) begin
                        sdiv_d   = div_i;
                        shigh_d  = high_i;
                        sphase_d = phase_i;
                        pend_d   = 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            div_q     <= DIV_W'(DIV_RST);
            high_q    <= DIV_W'(HIGH_RST);
            phase_q   <= DIV_W'(PHASE_RST);
            sdiv_q    <= DIV_W'(DIV_RST);
            shigh_q   <= DIV_W'(HIGH_RST);
            sphase_q  <= DIV_W'(PHASE_RST);
            pend_q    <= 1'b0;
            clk_out_q <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            div_q     <= div_d;
            high_q    <= high_d;
            phase_q   <= phase_d;
            sdiv_q    <= sdiv_d;
            shigh_q   <= shigh_d;
            sphase_q  <= sphase_d;
            pend_q    <= pend_d;
            clk_out_q <= clk_out_d;
            tick_q    <= tick_d;
        end
    end

    assign clk_out_o = clk_out_q;
    assign tick_o    = tick_q;
    assign running_o = (state_q != ST_IDLE);
    assign pending_o = pend_q;

endmodule
`default_nettype wire

// File: rtl/clock_div_multi.sv
`default_nettype none
// ============================================================================
//  Module      : clock_div_multi
//  Description : NUM_CH independent programmable clock/strobe generators
//                derived from one master clock, with a common sync restart.
//  Revision    : 1.0 - initial release
//
//  Ports
//    clk          master clock           reset        async active-low reset
//    cfg_we       config write strobe    cfg_ch       target channel
//    cfg_div      period (cycles)        cfg_high     high time (cycles)
//    cfg_phase    start counter value    ch_en        per-channel run request
//    sync         restart running chans  clk_out      divided clocks
//    tick         cnt==0 strobes         running      channel counting
//    cfg_pending  shadow config waiting for a period boundary
// ============================================================================
module clock_div_multi
    import clock_div_pkg::*;
#(
    parameter  int NUM_CH = 4,
    parameter  int DIV_W  = DIV_W_DEF,
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [DIV_W-1:0]  cfg_div,
    input  logic [DIV_W-1:0]  cfg_high,
    input  logic [DIV_W-1:0]  cfg_phase,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              sync,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] running,
    output logic [NUM_CH-1:0] cfg_pending
);

    // Clamp once here; every channel sees the same broadcast values and
    // only the addressed one acts on them.
    logic [DIV_W-1:0] w_div_c, w_high_c, w_phase_c;

    assign w_div_c   = DIV_W'(clamp_div(32'(cfg_div)));
    assign w_high_c  = DIV_W'(clamp_high(32'(cfg_high), 32'(w_div_c)));
    assign w_phase_c = DIV_W'(clamp_phase(32'(cfg_phase), 32'(w_div_c)));

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic w_we;

        // Channel numbers at or above NUM_CH never match, so those
        // writes are dropped.
        assign w_we = cfg_we && (cfg_ch == CH_W'(i));

        clock_div_channel #(
            .DIV_W (DIV_W)
        ) u_ch (
            .clk_i     (clk),
            .rst_ni    (reset),
            .we_i      (w_we),
            .div_i     (w_div_c),
            .high_i    (w_high_c),
            .phase_i   (w_phase_c),
            .en_i      (ch_en[i]),
            .sync_i    (sync),
            .clk_out_o (clk_out[i]),
            .tick_o    (tick[i]),
            .running_o (running[i]),
            .pending_o (cfg_pending[i])
        );
    end

endmodule
`default_nettype wire

// File: doc/clock_div_multi.md
Name: clock_div_multi

Overview:
Synthesizable multi-channel clock/strobe generator, the parametrised successor to the behavioural testbench clock model. It derives NUM_CH divided clocks from one master clock. Each channel has a programmable divisor, high time (duty) and phase offset, glitch-free config update and stop, plus a common sync restart. It feeds the ruler-search datapath and benches that need several related clock/enable rates.

Parameters:
NUM_CH, 4, number of output channels (>=1)
DIV_W, 16, width of divisor/high/phase fields
CH_W, $clog2(NUM_CH) (min 1), derived localparam, channel-select width

Ports:
clk  input  1  master clock; all state on rising edge
reset  input  1  reset: asynchronous, active-low
cfg_we  input  1  config write strobe, one cycle
cfg_ch  input  CH_W  target channel; values >= NUM_CH are ignored
cfg_div  input  DIV_W  period in clk cycles
cfg_high  input  DIV_W  cycles clk_out is high per period
cfg_phase  input  DIV_W  initial counter value on start/sync
ch_en  input  NUM_CH  per-channel run request
sync  input  1  restart all enabled running channels at their phase
clk_out  output  NUM_CH  divided clocks, driven directly from flops
tick  output  NUM_CH  one-cycle strobe, high while channel counter == 0
running  output  NUM_CH  channel counting (includes stopping)
cfg_pending  output  NUM_CH  shadow config waiting for period boundary

Behaviour:
- Reset (async assert, sync release): all outputs 0. Per channel: cnt=0, div=2, high=1, phase=0, shadow=same, pending=0.
- Clamping at write: div_c = max(cfg_div, 2); high_c = min(max(cfg_high, 1), div_c-1); phase_c = cfg_phase if < div_c, else 0.
- Config write to an idle channel (running=0): loads active regs directly, pending stays 0.
- Config write to a running channel: loads shadow, pending=1. A later write overwrites the shadow.
- Shadow application: at wrap (cnt==div-1 -> 0) if pending. New values are in force for the cnt=0 cycle; pending clears.
- Start: at a clk edge where ch_en=1 and running=0, set running=1, cnt=phase, clk_out=(phase<high), tick=(phase==0). Zero added latency.
- Count: while running, cnt increments and wraps div-1 -> 0. clk_out=(cnt<high) and tick=(cnt==0) are registered with cnt.
- Stop is glitch-free: ch_en low while running lets the channel finish the current period. At the edge where cnt would wrap to 0, running=0, cnt=0, clk_out=0, tick=0.
- ch_en re-asserted before that wrap cancels the stop; counting continues uninterrupted.
- sync=1: every channel with running=1 and ch_en=1 loads cnt=phase with outputs per the start rule, and any pending shadow is applied first. Stopping channels ignore sync.
- Simultaneous cfg write and sync on the same running channel: the written (clamped) values take effect immediately with the sync; pending=0.
- Simultaneous start and cfg write on the same channel: the written values are used for the start.
- Channels are fully independent except for sync. A reset mid-period forces all channels idle asynchronously.

Decomposition:
- Package clock_div_pkg: DIV_W default, reset config constants (DIV_RST=2, HIGH_RST=1, PHASE_RST=0), clamp function for (div, high, phase).
- Sub-module clock_div_channel: counter, active/shadow regs, start/stop/sync FSM (IDLE, RUN, STOPPING).
- Top: cfg_ch decode plus a generate loop over NUM_CH.

Test Plan:
- Reset, then write ch0 div=4 high=2 phase=0, raise ch_en[0] -> clk_out[0] = 1,1,0,0 repeating from the enable edge; tick[0] high every 4th cycle aligned with the first 1.
- ch1 div=5 high=9 (clamps to 4), div=1 (clamps to 2 with high=1) -> 1,1,1,1,0 pattern, then 1,0 pattern after idle rewrite.
- ch0 running div=4; write div=6 high=3 mid-period -> cfg_pending=1; old period completes, then 1,1,1,0,0,0; pending clears at the wrap.
- ch2 phase=2 and ch3 phase=0, both div=4 high=2, enabled together, then sync pulse -> ch2 restarts at 0,0,1,1 and ch3 at 1,1,0,0 on the cycle after sync.
- Drop ch_en[0] at cnt=1 of a div=4 period -> runs cnt 2,3; running=0 and clk_out=0 at the next edge; no runt pulse. Repeat with ch_en re-raised at cnt=2 -> no stop.
- Assert reset (low) mid-high phase on all channels -> clk_out, tick, running, cfg_pending all 0 immediately, without waiting for a clk edge.
